// File: rtl/cpu_pkg.sv
// Shared constants for the up/down modulo counter.
//   CNT_UP / CNT_DN      : values of the 'up' direction input
//   MODE_WRAP / MODE_SAT : values of the 'sat' boundary-mode input
package cpu_pkg;

  localparam int unsigned CTRL_W = 1;

  // Direction encoding for the 'up' input
  localparam logic [CTRL_W-1:0] CNT_UP = 1'b1;
  localparam logic [CTRL_W-1:0] CNT_DN = 1'b0;

  // Boundary behaviour encoding for the 'sat' input
  localparam logic [CTRL_W-1:0] MODE_WRAP = 1'b0;
  localparam logic [CTRL_W-1:0] MODE_SAT  = 1'b1;

endpackage : cpu_pkg

// File: rtl/counter_next.sv
// Combinational next-count computation for a modulo-MOD up/down counter.
// Ports:
//   count_i      : current count (N bits, always in 0..MOD-1)
//   up_i         : direction, CNT_UP increments, CNT_DN decrements
//   sat_i        : MODE_SAT holds at the boundary, MODE_WRAP wraps around
//   next_count_o : count after one enabled step
//   wrap_o       : 1 when this step wraps around the modulus
module counter_next
  import cpu_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned MOD = 2 ** N
) (
  input  logic [N-1:0] count_i,
  input  logic         up_i,
  input  logic         sat_i,
  output logic [N-1:0] next_count_o,
  output logic         wrap_o
);

  // Largest legal count; MOD may equal 2**N, so MOD itself is never formed in N bits
  localparam logic [N-1:0] LAST = N'(MOD - 1);

  logic at_top;
  logic at_bottom;

  assign at_top    = (count_i == LAST);
  assign at_bottom = (count_i == '0);

  // Step logic: explicit boundary compares, no reliance on N-bit overflow
  always_comb begin
    next_count_o = count_i;
    wrap_o       = 1'b0;
    if (up_i == CNT_UP) begin
      if (!at_top) begin
        next_count_o = count_i + N'(1);
      end else if (sat_i != MODE_SAT) begin
        next_count_o = '0;
        wrap_o       = 1'b1;
      end
    end else begin
      if (!at_bottom) begin
        next_count_o = count_i - N'(1);
      end else if (sat_i != MODE_SAT) begin
        next_count_o = LAST;
        wrap_o       = 1'b1;
      end
    end
  end

endmodule : counter_next

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MOD counter with parallel load, saturate/wrap mode and
// a registered one-cycle wrap pulse.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   clear : synchronous active-high reset (count=0, wrap=0)
//   en    : count enable
//   load  : parallel load request (takes priority over en)
//   din   : load value, clamped to MOD-1
//   up    : direction, 1 = increment, 0 = decrement
//   sat   : boundary mode, 1 = saturate, 0 = wrap
//   count : registered current count
//   tc    : combinational terminal count for the current direction
//   wrap  : registered pulse, high for the cycle after a wrap-around
module updown_mod_counter
  import cpu_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned MOD = 2 ** N
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         up,
  input  logic         sat,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         wrap
);

  localparam logic [N-1:0] LAST = N'(MOD - 1);

  // Reject illegal parameterisations at elaboration
  if (N < 1 || MOD < 2 || MOD > (2 ** N)) begin : g_bad_param
    $error("updown_mod_counter: require N >= 1 and 2 <= MOD <= 2**N");
  end

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic         wrap_q;
  logic         wrap_d;
  logic [N-1:0] step_count;
  logic         step_wrap;
  logic [N-1:0] load_val;

  counter_next #(
    .N   (N),
    .MOD (MOD)
  ) u_counter_next (
    .count_i      (count_q),
    .up_i         (up),
    .sat_i        (sat),
    .next_count_o (step_count),
    .wrap_o       (step_wrap)
  );

  // Out-of-range load values clamp to the top of the range
  assign load_val = (din > LAST) ? LAST : din;

  // Priority mux: load, then enabled step, else hold (clear is in the register)
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = step_count;
      wrap_d  = step_wrap;
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = (up == CNT_UP) ? (count_q == LAST) : (count_q == '0);

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: two counters (N=4/MOD=10 and N=2/MOD=4) driven by
// the same directed and random stimulus, compared against an arithmetic model.
module tb_updown_mod_counter;

  localparam int unsigned NA = 4;
  localparam int unsigned MA = 10;
  localparam int unsigned NB = 2;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          clear, en, load, up, sat;
  logic [NA-1:0] din;
  logic [NA-1:0] count_a;
  logic          tc_a, wrap_a;
  logic [NB-1:0] count_b;
  logic          tc_b, wrap_b;

  always #10 clk = ~clk;

  updown_mod_counter #(.N(NA), .MOD(MA)) dut_a (
    .clk(clk), .clear(clear), .en(en), .load(load), .din(din),
    .up(up), .sat(sat), .count(count_a), .tc(tc_a), .wrap(wrap_a)
  );

  updown_mod_counter #(.N(NB), .MOD(MB)) dut_b (
    .clk(clk), .clear(clear), .en(en), .load(load), .din(din[NB-1:0]),
    .up(up), .sat(sat), .count(count_b), .tc(tc_b), .wrap(wrap_b)
  );

  int checks = 0;
  int errors = 0;
  int mods[2] = '{MA, MB};
  int ref_cnt[2];
  bit ref_wrap[2];
  bit known = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tc_exp(input int k, input bit u);
    return u ? int'(ref_cnt[k] == mods[k] - 1) : int'(ref_cnt[k] == 0);
  endfunction

  // Reference: count lives in Z_MOD; a step adds +/-1 modulo MOD unless it
  // would cross the boundary in saturate mode.
  function automatic void model_edge(input int k, input bit c, input bit l,
                                     input bit e, input bit u, input bit s,
                                     input int d);
    int m;
    int nxt;
    bit crosses;
    m = mods[k];
    ref_wrap[k] = 1'b0;
    if (c) begin
      ref_cnt[k] = 0;
    end else if (l) begin
      ref_cnt[k] = (d > m - 1) ? m - 1 : d;
    end else if (e) begin
      nxt = ref_cnt[k] + (u ? 1 : -1);
      crosses = (nxt < 0) || (nxt >= m);
      if (!(crosses && s)) begin
        ref_cnt[k]  = (nxt + m) % m;
        ref_wrap[k] = crosses;
      end
    end
  endfunction

  // One clock: drive at negedge, check tc, clock, check registered outputs
  task automatic cycle(input bit c, input bit l, input bit e, input bit u,
                       input bit s, input int d);
    clear = c; load = l; en = e; up = u; sat = s; din = NA'(d);
    #1;
    if (known) begin
      check("tc_a", int'(tc_a), tc_exp(0, u));
      check("tc_b", int'(tc_b), tc_exp(1, u));
    end
    @(posedge clk);
    model_edge(0, c, l, e, u, s, d);
    model_edge(1, c, l, e, u, s, d % MB);
    if (c) known = 1'b1;
    @(negedge clk);
    if (known) begin
      check("count_a", int'(count_a), ref_cnt[0]);
      check("wrap_a",  int'(wrap_a),  int'(ref_wrap[0]));
      check("count_b", int'(count_b), ref_cnt[1]);
      check("wrap_b",  int'(wrap_b),  int'(ref_wrap[1]));
    end
  endtask

  int wraps_b;

  initial begin
    clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; din = '0;
    @(negedge clk);

    // Clear, then count up with wrap; 2-bit instance sees 0,1,2,3,0,1
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    check("reset_count_a", int'(count_a), 0);
    wraps_b = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 1, 0, 0);
      if (i < 6) wraps_b += int'(wrap_b);
    end
    check("wraps_b_6cyc", wraps_b, 1);

    // Load 3 then count down through 0 -> 9
    cycle(0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, 0);
    check("down_end_a", int'(count_a), 8);

    // Saturate up from 8, then saturate down from 1
    cycle(0, 1, 0, 1, 1, 8);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 1, 0);
    check("sat_top_a", int'(count_a), 9);
    cycle(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 1, 0);
    check("sat_bot_a", int'(count_a), 0);

    // Out-of-range load clamps; load beats en
    cycle(0, 1, 0, 1, 0, 13);
    check("clamp_a", int'(count_a), 9);
    cycle(0, 1, 1, 1, 0, 5);
    check("load_over_en_a", int'(count_a), 5);

    // Clear on the wrap edge, then hold with en=0
    cycle(0, 1, 0, 1, 0, 9);
    cycle(1, 0, 1, 1, 0, 0);
    check("clear_wrap_a", int'(wrap_a), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    check("hold_a", int'(count_a), 0);

    // Clear during a live wrap pulse drops it
    cycle(0, 1, 0, 1, 0, 9);
    cycle(0, 0, 1, 1, 0, 0);
    check("wrap_pulse_a", int'(wrap_a), 1);
    cycle(1, 0, 1, 1, 0, 0);

    // Random stimulus
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 75), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter N, default 4: counter width in bits; SHALL be at least 1.
REQ-002 Parameter MOD, default 2**N: count modulus; SHALL satisfy 2 <= MOD <= 2**N.
REQ-003 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 clear  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  count enable; a step occurs only on an enabled edge.
REQ-006 load  input  1  parallel load request.
REQ-007 din  input  N  parallel load value.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement; sampled per edge.
REQ-009 sat  input  1  boundary mode: 1 = saturate, 0 = wrap; sampled per edge.
REQ-010 count  output  N  current count, registered.
REQ-011 tc  output  1  terminal count, combinational from count and up.
REQ-012 wrap  output  1  one-cycle registered pulse marking a wrap-around.

Function
REQ-013 Per-edge priority SHALL be: clear, then load, then en, then hold.
REQ-014 Load: count SHALL take din when din <= MOD-1, otherwise MOD-1; wrap SHALL be 0.
REQ-015 Up step: when count < MOD-1, count SHALL become count+1.
REQ-016 Down step: when count > 0, count SHALL become count-1.
REQ-017 Up at MOD-1 with sat=0: count SHALL become 0 and wrap SHALL be 1 for the next cycle only.
REQ-018 Down at 0 with sat=0: count SHALL become MOD-1 and wrap SHALL be 1 for the next cycle only.
REQ-019 Boundary with sat=1: count SHALL hold, and wrap SHALL be 0.
REQ-020 en=0 with load=0: count SHALL hold, and wrap SHALL be 0 on that edge.
REQ-021 tc SHALL be 1 when up=1 and count=MOD-1, or when up=0 and count=0; otherwise 0.
REQ-022 A direction change takes effect on the same edge as sampled; tc follows up combinationally.
REQ-023 Step latency SHALL be one clock; no step is ever lost or doubled.
REQ-024 Arithmetic SHALL be N bits wide with no reliance on natural overflow; MOD < 2**N SHALL wrap at MOD.
REQ-025 load with en=1 SHALL load only; no step is added on that edge.

Reset
REQ-026 clear=1 at a rising edge SHALL set count=0 and wrap=0, overriding load and en.
REQ-027 A clear asserted mid-count or during a wrap pulse SHALL take effect on that edge; the pending pulse is dropped.
REQ-028 No asynchronous reset path SHALL exist; before the first clear, state is undefined.

Structure
REQ-029 The direction constants (CNT_UP=1, CNT_DN=0) and mode constants (MODE_WRAP=0, MODE_SAT=1) SHALL reside in the shared package cpu_pkg.
REQ-030 One combinational sub-module, counter_next, SHALL compute the next count and the wrap event from count, up, sat and MOD.
REQ-031 The top level SHALL hold only the priority mux and the registers for count and wrap.

Verification
REQ-032 The bench SHALL use N=4, MOD=10 unless stated otherwise, with the clk period at 20 ns.
REQ-033 Scenario: clear for 2 cycles, then en=1, up=1, sat=0 for 12 cycles -> count 0..9, 0, 1; wrap high exactly one cycle, the cycle after 9->0; tc=1 only while count=9.
REQ-034 Scenario: load din=3, then up=0, en=1 for 5 cycles, sat=0 -> count 3, 2, 1, 0, 9, 8; wrap pulses once after 0->9; tc=1 at count=0.
REQ-035 Scenario: sat=1, load din=8, then up=1, en=1 for 4 cycles -> count 8, 9, 9, 9; wrap stays 0. Then up=0 from load 1 -> count 1, 0, 0; wrap stays 0.
REQ-036 Scenario: load din=13 (>= MOD) -> count=9. Then load=1 and en=1 together with din=5 -> count=5, not 6.
REQ-037 Scenario: at count=9 with up=1, en=1, assert clear on the wrap edge -> count=0 and wrap=0 the next cycle. Then en=0 for 3 cycles -> count holds at 0.
REQ-038 Scenario: N=2, MOD=4, en=1, up=1 for 6 cycles -> count 0, 1, 2, 3, 0, 1; one wrap pulse; matches the original 2-bit counter sequence.
